jtframe_shadow_mc: RTL and testbench
====================================

JTFRAME_SHADOW_MC -- requirements
Module: jtframe_shadow_mc

Interface
REQ-001 SHALL have parameter AW, default 22: SDRAM bank-0 address width (word address).
REQ-002 SHALL have parameter CH, default 2: number of capture windows; legal values 1, 2, 4.
REQ-003 SHALL have parameter LW, default 15: log2 of words per window.
REQ-004 SHALL have parameters START0..START3, defaults 22'h10_0000, 22'h18_0000, 22'h20_0000, 22'h28_0000: window base addresses; STARTn with n>=CH is ignored.
REQ-005 SHALL have port clk_rom  in  1: single clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst  in  1: synchronous active-high reset.
REQ-007 SHALL have port ba0_addr  in  AW: bank-0 word address.
REQ-008 SHALL have port wr0  in  1: bank-0 write strobe, one cycle per write.
REQ-009 SHALL have port din  in  16: write data.
REQ-010 SHALL have port din_m  in  2: byte write mask, active low.
REQ-011 SHALL have port freeze  in  1: level; high blocks captures.
REQ-012 SHALL have port clr  in  1: one-cycle pulse requesting a shadow clear.
REQ-013 SHALL have port ioctl_addr  in  AW: dump byte address.
REQ-014 SHALL have port ioctl_din  out  8: dump byte.
REQ-015 SHALL have port busy  out  1: high while clearing.
REQ-016 SHALL have port hits  out  16: captured-write count.

Function
REQ-017 SHALL hold a shadow RAM of CH*2^LW 16-bit words; window n occupies words n*2^LW .. (n+1)*2^LW-1.
REQ-018 SHALL treat a write as a hit on window n when wr0=1 and STARTn <= ba0_addr < STARTn+2^LW; the lowest-index hit window wins on overlap.
REQ-019 SHALL register hit, window index, offset (ba0_addr-STARTn truncated to LW bits), din and ~din_m for one cycle, then write the RAM, giving 1-cycle capture latency.
REQ-020 SHALL not write when wr0=0, when no window hits, or when din_m=2'b11.
REQ-021 SHALL implement FSM states CLEAR, RUN, FROZEN.
REQ-022 SHALL, in CLEAR, write 16'h0000 with both bytes enabled to address clr_cnt, increment clr_cnt each cycle, and go to RUN (FROZEN if freeze=1) after word CH*2^LW-1; busy=1 only in CLEAR.
REQ-023 SHALL drop every capture arriving during CLEAR; the clear write owns the RAM write port.
REQ-024 SHALL move RUN->FROZEN on freeze=1 and FROZEN->RUN on freeze=0, effective the next cycle; captures are dropped in FROZEN.
REQ-025 SHALL, on clr=1 in any state, enter CLEAR with clr_cnt=0 and hits=0; clr during CLEAR restarts from word 0.
REQ-026 SHALL increment hits on every RAM write performed by a capture, saturating at 16'hFFFF.
REQ-027 SHALL read RAM word ioctl_addr[LW+log2(CH):1] through a registered port, with ioctl_addr[0] delayed one cycle to select the byte (1=high, 0=low); ioctl_din reflects ioctl_addr from the previous cycle.
REQ-028 SHALL keep the read port independent of FSM state; during CLEAR reads return whatever has been cleared so far.
REQ-029 SHALL return the new data when a read and a capture write hit the same word in the same cycle; no read-old-data behaviour is relied upon.

Reset
REQ-030 SHALL, on rst=1, enter CLEAR with clr_cnt=0, hits=0, busy=1 next cycle, and capture stage invalid; ioctl_din=8'h00 while rst=1.
REQ-031 SHALL restart a clear in progress when rst is asserted mid-clear.

Structure
REQ-032 SHALL instantiate jtframe_dual_ram16 (aw=LW+log2(CH)) as its only sub-module: port 0 = capture/clear writes, port 1 = dump reads.
REQ-033 SHALL keep FSM encodings and window decode local; no shared package is needed.

Verification
REQ-034 Reset, then wait CH*2^LW+2 cycles: busy falls exactly after 65536 cycles (CH=2, LW=15); every ioctl address reads 8'h00.
REQ-035 wr0 with ba0_addr=22'h10_0005, din=16'hA55A, din_m=2'b00: hits=1; ioctl_addr=10 -> 8'h5A, ioctl_addr=11 -> 8'hA5.
REQ-036 Write ba0_addr=22'h18_0003, din=16'h1234, din_m=2'b10: only the low byte is stored; ioctl_addr=22'h1_0006 -> 8'h34, 22'h1_0007 -> 8'h00.
REQ-037 freeze=1, then write 22'h10_0000 with din=16'hFFFF: RAM unchanged, hits unchanged; after freeze=0 the same write lands.
REQ-038 Write to 22'h0F_FFFF and 22'h10_8000 (outside both windows): no RAM change, hits unchanged.
REQ-039 clr pulse mid-traffic with hits=16'hFFFF saturated: hits=0 next cycle, busy=1, captures during clear dropped, all words read 0 afterwards.

Source files
------------

// File: rtl/jtframe_shadow_mc_pkg.sv
// rtl/jtframe_shadow_mc_pkg.sv - shared constants and helpers for the shadow capture block
package jtframe_shadow_mc_pkg;

  localparam int DW = 16;

  // Number of address bits needed to select one of CH windows (CH is 1, 2 or 4).
  function automatic int ch_bits(input int ch);
    return (ch >= 4) ? 2 : ((ch >= 2) ? 1 : 0);
  endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// rtl/jtframe_dual_ram16.sv - 16-bit dual-port RAM, byte-write port 0, read port 1
//
// Ports:
//   clk    : single clock for both ports
//   data0  : port 0 write data
//   addr0  : port 0 word address
//   we0    : port 0 byte write enables, active high ([1]=high byte)
//   addr1  : port 1 word address
//   q1     : port 1 registered read data
module jtframe_dual_ram16
  import jtframe_shadow_mc_pkg::*;
#(
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic [1:0]    we0,
  input  logic [aw-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(1<<aw)-1];
  logic          w_same;

  assign w_same = (addr0 == addr1);

  always_ff @(posedge clk) begin
    if (we0[0]) mem[addr0][7:0]  <= data0[7:0];
    if (we0[1]) mem[addr0][15:8] <= data0[15:8];
  end

  // A read colliding with a write to the same word returns the freshly
  // written byte lanes, so callers never see stale data.
  always_ff @(posedge clk) begin
    q1[7:0]  <= (we0[0] && w_same) ? data0[7:0]  : mem[addr1][7:0];
    q1[15:8] <= (we0[1] && w_same) ? data0[15:8] : mem[addr1][15:8];
  end

endmodule

// File: rtl/jtframe_shadow_mc.sv
// rtl/jtframe_shadow_mc.sv - shadow RAM capturing SDRAM bank-0 writes into address windows
//
// Ports:
//   clk_rom    : clock
//   rst        : synchronous active-high reset
//   ba0_addr   : bank-0 word address
//   wr0        : bank-0 write strobe, one cycle per write
//   din        : write data
//   din_m      : byte write mask, active low
//   freeze     : level, high blocks captures
//   clr        : one-cycle shadow clear request
//   ioctl_addr : dump byte address
//   ioctl_din  : dump byte, one cycle after ioctl_addr
//   busy       : high while clearing
//   hits       : saturating count of captured RAM writes
module jtframe_shadow_mc
  import jtframe_shadow_mc_pkg::*;
#(
  parameter int            AW     = 22,
  parameter int            CH     = 2,
  parameter int            LW     = 15,
  parameter logic [AW-1:0] START0 = 22'h10_0000,
  parameter logic [AW-1:0] START1 = 22'h18_0000,
  parameter logic [AW-1:0] START2 = 22'h20_0000,
  parameter logic [AW-1:0] START3 = 22'h28_0000
) (
  input  logic          clk_rom,
  input  logic          rst,
  input  logic [AW-1:0] ba0_addr,
  input  logic          wr0,
  input  logic [15:0]   din,
  input  logic [1:0]    din_m,
  input  logic          freeze,
  input  logic          clr,
  input  logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          busy,
  output logic [15:0]   hits
);

  localparam int            WB    = ch_bits(CH);
  localparam int            RAW   = LW + WB;
  localparam logic [AW:0]   WSIZE = {{AW{1'b0}}, 1'b1} << LW;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_FROZEN} state_t;

  state_t         r_state, w_next;
  logic [RAW-1:0] r_clr_cnt;
  logic [15:0]    r_hits;

  logic           r_hit;
  logic [1:0]     r_win;
  logic [LW-1:0]  r_off;
  logic [15:0]    r_din;
  logic [1:0]     r_be;

  logic           w_hit;
  logic [1:0]     w_win;
  logic [LW-1:0]  w_off;
  logic           w_cap_we;
  logic [1:0]     w_we0;
  logic [RAW-1:0] w_addr0;
  logic [15:0]    w_data0;
  logic [15:0]    w_q1;
  logic           r_sel;
  logic           w_unused_addr;

  function automatic logic [AW-1:0] win_base(input int n);
    case (n)
      0:       return START0;
      1:       return START1;
      2:       return START2;
      default: return START3;
    endcase
  endfunction

  // Scanning from the top index down lets the lowest matching window win.
  always_comb begin
    w_hit = 1'b0;
    w_win = 2'd0;
    w_off = '0;
    for (int n = CH - 1; n >= 0; n--) begin
      if (({1'b0, ba0_addr} >= {1'b0, win_base(n)}) &&
          ({1'b0, ba0_addr} <  ({1'b0, win_base(n)} + WSIZE))) begin
        w_hit = 1'b1;
        w_win = 2'(n);
        w_off = LW'(ba0_addr - win_base(n));
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst || clr) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= wr0 && w_hit && (r_state == ST_RUN);
    end
    r_win <= w_win;
    r_off <= w_off;
    r_din <= din;
    r_be  <= ~din_m;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR:  if (&r_clr_cnt) w_next = freeze ? ST_FROZEN : ST_RUN;
      ST_RUN:    if (freeze)     w_next = ST_FROZEN;
      ST_FROZEN: if (!freeze)    w_next = ST_RUN;
      default:   w_next = ST_CLEAR;
    endcase
    if (clr) w_next = ST_CLEAR;
  end

  always_ff @(posedge clk_rom) begin
    if (rst || clr)              r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // The clear sweep owns the write port, so a pending capture is lost there.
  assign w_cap_we = r_hit && (|r_be) && (r_state != ST_CLEAR);

  always_ff @(posedge clk_rom) begin
    if (rst || clr)                        r_hits <= 16'h0000;
    else if (w_cap_we && r_hits != 16'hFFFF) r_hits <= r_hits + 16'h0001;
  end

  always_comb begin
    w_we0   = 2'b00;
    w_addr0 = RAW'({r_win, r_off});
    w_data0 = r_din;
    if (r_state == ST_CLEAR) begin
      w_we0   = 2'b11;
      w_addr0 = r_clr_cnt;
      w_data0 = 16'h0000;
    end else if (w_cap_we) begin
      w_we0   = r_be;
    end
  end

  jtframe_dual_ram16 #(
    .aw    (RAW)
  ) u_ram (
    .clk   (clk_rom),
    .data0 (w_data0),
    .addr0 (w_addr0),
    .we0   (w_we0),
    .addr1 (ioctl_addr[RAW:1]),
    .q1    (w_q1)
  );

  always_ff @(posedge clk_rom) begin
    if (rst) r_sel <= 1'b0;
    else     r_sel <= ioctl_addr[0];
  end

  assign w_unused_addr = ^ioctl_addr;
  assign ioctl_din     = rst ? 8'h00 : (r_sel ? w_q1[15:8] : w_q1[7:0]);
  assign busy          = (r_state == ST_CLEAR);
  assign hits          = r_hits;

endmodule

// File: tb/tb_jtframe_shadow_mc.sv
// tb/tb_jtframe_shadow_mc.sv - directed table-driven bench for jtframe_shadow_mc
module tb_jtframe_shadow_mc;

  localparam int AW    = 22;
  localparam int CH    = 2;
  localparam int LW    = 4;
  localparam int WORDS = CH << LW;

  logic          clk_rom = 1'b0;
  logic          rst;
  logic [AW-1:0] ba0_addr;
  logic          wr0;
  logic [15:0]   din;
  logic [1:0]    din_m;
  logic          freeze;
  logic          clr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          busy;
  logic [15:0]   hits;

  int checks   = 0;
  int failures = 0;

  jtframe_shadow_mc #(
    .AW (AW),
    .CH (CH),
    .LW (LW)
  ) dut (
    .clk_rom    (clk_rom),
    .rst        (rst),
    .ba0_addr   (ba0_addr),
    .wr0        (wr0),
    .din        (din),
    .din_m      (din_m),
    .freeze     (freeze),
    .clr        (clr),
    .ioctl_addr (ioctl_addr),
    .ioctl_din  (ioctl_din),
    .busy       (busy),
    .hits       (hits)
  );

  always #5 clk_rom = ~clk_rom;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   d;
    logic [1:0]    m;
    logic          inc;
    logic [AW-1:0] rd;
    logic [7:0]    lo;
    logic [7:0]    hi;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] m);
    wr0 = w; ba0_addr = a; din = d; din_m = m;
    step();
    wr0 = 1'b0;
    step();
  endtask

  task automatic read_byte(input logic [AW-1:0] a, output logic [7:0] v);
    ioctl_addr = a;
    step();
    v = ioctl_din;
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] v;
    for (int i = 0; i < 2 * WORDS; i++) begin
      read_byte(AW'(i), v);
      check(name, {8'h00, v}, 16'h0000);
    end
  endtask

  task automatic wait_clear(input string name, input logic keep_writing);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (keep_writing) begin
        ba0_addr = 22'h10_0000 + AW'(n & 15);
        din      = 16'hDEAD;
      end
      step();
      n++;
    end
    wr0 = 1'b0;
    check(name, 16'(n), 16'(WORDS));
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] exp_hits;

    vecs[0] = '{1'b1, 22'h10_0005, 16'hA55A, 2'b00, 1'b1, 22'd10, 8'h5A, 8'hA5};
    vecs[1] = '{1'b1, 22'h18_0003, 16'h1234, 2'b10, 1'b1, 22'd38, 8'h34, 8'h00};
    vecs[2] = '{1'b1, 22'h18_0003, 16'hABCD, 2'b01, 1'b1, 22'd38, 8'h34, 8'hAB};
    vecs[3] = '{1'b1, 22'h10_0005, 16'h0000, 2'b11, 1'b0, 22'd10, 8'h5A, 8'hA5};
    vecs[4] = '{1'b1, 22'h0F_FFFF, 16'hFFFF, 2'b00, 1'b0, 22'd0,  8'h00, 8'h00};
    vecs[5] = '{1'b1, 22'h10_0010, 16'hFFFF, 2'b00, 1'b0, 22'd0,  8'h00, 8'h00};
    vecs[6] = '{1'b1, 22'h18_000F, 16'hBEEF, 2'b00, 1'b1, 22'd62, 8'hEF, 8'hBE};
    vecs[7] = '{1'b1, 22'h10_0000, 16'hC0DE, 2'b00, 1'b1, 22'd0,  8'hDE, 8'hC0};
    vecs[8] = '{1'b1, 22'h17_FFFF, 16'h1111, 2'b00, 1'b0, 22'd30, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 22'h10_0001, 16'h7777, 2'b00, 1'b0, 22'd2,  8'h00, 8'h00};

    rst = 1'b1; wr0 = 1'b0; ba0_addr = '0; din = '0; din_m = 2'b00;
    freeze = 1'b0; clr = 1'b0; ioctl_addr = 22'd10;
    step(); step(); step();
    check("rst_ioctl_din", {8'h00, ioctl_din}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0001);
    check("rst_hits", hits, 16'h0000);

    rst = 1'b0;
    wait_clear("reset_clear_len", 1'b0);
    check_all_zero("reset_zero");

    exp_hits = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].wr, vecs[i].addr, vecs[i].d, vecs[i].m);
      if (vecs[i].inc) exp_hits++;
      check($sformatf("vec%0d_hits", i), hits, exp_hits);
      read_byte(vecs[i].rd, v);
      check($sformatf("vec%0d_lo", i), {8'h00, v}, {8'h00, vecs[i].lo});
      read_byte(vecs[i].rd + 22'd1, v);
      check($sformatf("vec%0d_hi", i), {8'h00, v}, {8'h00, vecs[i].hi});
    end

    freeze = 1'b1;
    step(); step();
    do_write(1'b1, 22'h10_0000, 16'hFFFF, 2'b00);
    check("frozen_hits", hits, exp_hits);
    read_byte(22'd0, v);
    check("frozen_lo", {8'h00, v}, 16'h00DE);
    read_byte(22'd1, v);
    check("frozen_hi", {8'h00, v}, 16'h00C0);
    freeze = 1'b0;
    step();
    do_write(1'b1, 22'h10_0000, 16'hFFFF, 2'b00);
    exp_hits++;
    check("thaw_hits", hits, exp_hits);
    read_byte(22'd0, v);
    check("thaw_lo", {8'h00, v}, 16'h00FF);
    read_byte(22'd1, v);
    check("thaw_hi", {8'h00, v}, 16'h00FF);

    wr0 = 1'b1; ba0_addr = 22'h10_0007; din = 16'h5678; din_m = 2'b00;
    step();
    wr0 = 1'b0; ioctl_addr = 22'd14;
    step();
    exp_hits++;
    check("bypass_read", {8'h00, ioctl_din}, 16'h0078);
    check("bypass_hits", hits, exp_hits);

    wr0 = 1'b1; din_m = 2'b00;
    for (int i = 0; i < 65540; i++) begin
      ba0_addr = 22'h10_0000 + AW'(i & 15);
      din      = 16'(i);
      step();
    end
    check("hits_saturated", hits, 16'hFFFF);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_hits", hits, 16'h0000);
    check("clr_busy", {15'h0, busy}, 16'h0001);
    wait_clear("clr_clear_len", 1'b1);
    step();
    check("post_clr_hits", hits, 16'h0000);
    check_all_zero("post_clr_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
